// File: rtl/vscale_csr_access_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : vscale_csr_access_stage                                     |
// | Purpose  : WB-stage front end of the CSR file. Registers CSR commands  |
// |            from DX, performs the RW/RS/RC read-modify-write, flags    |
// |            illegal accesses, returns the old CSR value for rd, and    |
// |            fences DX after interrupt-enable-affecting writes.         |
// | Options  : VSCALE_CSR_STRICT_RO_EN - writes to read-only CSRs         |
// |            (addr[11:10]==2'b11) raise an illegal-instruction request. |
// |            Undefined: such writes are silently dropped.               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module vscale_csr_access_stage #(
  parameter int XPR_LEN    = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_dx,
  input  logic [1:0]            csr_cmd_dx,
  input  logic [CSR_ADDR_W-1:0] csr_addr_dx,
  input  logic [XPR_LEN-1:0]    csr_operand_dx,
  input  logic                  src_zero_dx,
  input  logic                  stall_wb,
  input  logic                  kill_wb,
  input  logic [1:0]            prv,
  input  logic [XPR_LEN-1:0]    csr_rdata,
  input  logic                  csr_defined,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic                  csr_en,
  output logic                  csr_wen,
  output logic [XPR_LEN-1:0]    csr_wdata,
  output logic [XPR_LEN-1:0]    rd_wdata_wb,
  output logic                  illegal_csr_wb,
  output logic                  fence_dx
);

  localparam logic [1:0] c_CMD_NONE = 2'd0;
  localparam logic [1:0] c_CMD_RW   = 2'd1;
  localparam logic [1:0] c_CMD_RS   = 2'd2;
  localparam logic [1:0] c_CMD_RC   = 2'd3;

  localparam logic [CSR_ADDR_W-1:0] c_ADDR_MSTATUS = CSR_ADDR_W'(12'h300);
  localparam logic [CSR_ADDR_W-1:0] c_ADDR_MIE     = CSR_ADDR_W'(12'h304);
  localparam logic [CSR_ADDR_W-1:0] c_ADDR_MIP     = CSR_ADDR_W'(12'h344);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_FENCE = 1'b1;

  logic                  valid_wb_q,    valid_wb_d;
  logic [1:0]            cmd_wb_q,      cmd_wb_d;
  logic [CSR_ADDR_W-1:0] addr_wb_q,     addr_wb_d;
  logic [XPR_LEN-1:0]    operand_wb_q,  operand_wb_d;
  logic                  src_zero_wb_q, src_zero_wb_d;
  logic [0:0]            state_q,       state_d;

  logic w_write_req;
  logic w_ro_write;
  logic w_ro_violation;
  logic w_priv_fail;
  logic w_illegal;
  logic w_fence_addr;

  // WB register next state: hold on stall, kill squashes the instruction
  always_comb begin
    valid_wb_d    = valid_wb_q;
    cmd_wb_d      = cmd_wb_q;
    addr_wb_d     = addr_wb_q;
    operand_wb_d  = operand_wb_q;
    src_zero_wb_d = src_zero_wb_q;
    if (!stall_wb) begin
      valid_wb_d    = valid_dx;
      cmd_wb_d      = csr_cmd_dx;
      addr_wb_d     = csr_addr_dx;
      operand_wb_d  = csr_operand_dx;
      src_zero_wb_d = src_zero_dx;
    end
    if (kill_wb) begin
      valid_wb_d = 1'b0;
    end
  end

  // WB register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_wb_q    <= 1'b0;
      cmd_wb_q      <= c_CMD_NONE;
      addr_wb_q     <= '0;
      operand_wb_q  <= '0;
      src_zero_wb_q <= 1'b0;
    end else begin
      valid_wb_q    <= valid_wb_d;
      cmd_wb_q      <= cmd_wb_d;
      addr_wb_q     <= addr_wb_d;
      operand_wb_q  <= operand_wb_d;
      src_zero_wb_q <= src_zero_wb_d;
    end
  end

  // Access qualification: RS/RC with a zero source are pure reads
  assign csr_addr    = addr_wb_q;
  assign csr_en      = valid_wb_q & (cmd_wb_q != c_CMD_NONE) & ~kill_wb;
  assign w_write_req = (cmd_wb_q == c_CMD_RW) |
                       (((cmd_wb_q == c_CMD_RS) | (cmd_wb_q == c_CMD_RC)) & ~src_zero_wb_q);
  assign w_ro_write  = w_write_req & (addr_wb_q[CSR_ADDR_W-1 -: 2] == 2'b11);
  assign w_priv_fail = (addr_wb_q[9:8] > prv);

`ifdef VSCALE_CSR_STRICT_RO_EN
  assign w_ro_violation = w_ro_write;
`else
  assign w_ro_violation = 1'b0;
`endif

  assign w_illegal = csr_en & (~csr_defined | w_priv_fail | w_ro_violation);

  // A read-only write is never committed, trapping or not
  assign csr_wen        = csr_en & w_write_req & ~w_illegal & ~w_ro_write & ~stall_wb;
  assign illegal_csr_wb = w_illegal & ~stall_wb;
  assign rd_wdata_wb    = csr_en ? csr_rdata : '0;

  // Read-modify-write data at full operand width
  always_comb begin
    csr_wdata = '0;
    case (cmd_wb_q)
      c_CMD_RW: csr_wdata = operand_wb_q;
      c_CMD_RS: csr_wdata = csr_rdata | operand_wb_q;
      c_CMD_RC: csr_wdata = csr_rdata & ~operand_wb_q;
      default:  csr_wdata = '0;
    endcase
  end

  assign w_fence_addr = (addr_wb_q == c_ADDR_MSTATUS) |
                        (addr_wb_q == c_ADDR_MIE) |
                        (addr_wb_q == c_ADDR_MIP);

  // Fence FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fence FSM next state: one FENCE cycle after an interrupt-state write
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (csr_wen & w_fence_addr) state_d = c_ST_FENCE;
      c_ST_FENCE: state_d = c_ST_IDLE;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // Fence FSM output
  always_comb begin
    fence_dx = (state_q == c_ST_FENCE);
  end

endmodule
`default_nettype wire

// File: tb/tb_vscale_csr_access_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_vscale_csr_access_stage                                  |
// | Purpose  : Self-checking bench: directed vector table, hand-written    |
// |            stall/kill/reset/fence sequences, and random traffic       |
// |            against a behavioural model of the WB CSR stage.           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_vscale_csr_access_stage;

`ifdef VSCALE_CSR_STRICT_RO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_dx;
  logic [1:0]  csr_cmd_dx;
  logic [11:0] csr_addr_dx;
  logic [31:0] csr_operand_dx;
  logic        src_zero_dx;
  logic        stall_wb;
  logic        kill_wb;
  logic [1:0]  prv;
  logic [31:0] csr_rdata;
  logic        csr_defined;
  logic [11:0] csr_addr;
  logic        csr_en;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] rd_wdata_wb;
  logic        illegal_csr_wb;
  logic        fence_dx;

  int errors = 0;
  int checks = 0;

  vscale_csr_access_stage #(.XPR_LEN(32), .CSR_ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .valid_dx(valid_dx), .csr_cmd_dx(csr_cmd_dx),
    .csr_addr_dx(csr_addr_dx), .csr_operand_dx(csr_operand_dx),
    .src_zero_dx(src_zero_dx), .stall_wb(stall_wb), .kill_wb(kill_wb),
    .prv(prv), .csr_rdata(csr_rdata), .csr_defined(csr_defined),
    .csr_addr(csr_addr), .csr_en(csr_en), .csr_wen(csr_wen),
    .csr_wdata(csr_wdata), .rd_wdata_wb(rd_wdata_wb),
    .illegal_csr_wb(illegal_csr_wb), .fence_dx(fence_dx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_dx();
    valid_dx = 1'b0; csr_cmd_dx = 2'd0; csr_addr_dx = 12'h0;
    csr_operand_dx = 32'h0; src_zero_dx = 1'b0;
  endtask

  // Drive a DX instruction now (phase: posedge+1)
  task automatic issue(input logic [1:0] cmd, input logic [11:0] addr,
                       input logic [31:0] op, input logic sz);
    valid_dx = 1'b1; csr_cmd_dx = cmd; csr_addr_dx = addr;
    csr_operand_dx = op; src_zero_dx = sz;
    stall_wb = 1'b0; kill_wb = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [11:0] addr;
    logic [31:0] op;
    logic        sz;
    logic [1:0]  prv;
    logic [31:0] rdata;
    logic        def;
    logic        exp_en;
    logic        exp_wen;
    logic        chk_wd;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[11];

  // Behavioural model state: the instruction sitting in WB
  logic        m_valid;
  logic [1:0]  m_cmd;
  logic [11:0] m_addr;
  logic [31:0] m_op;
  logic        m_sz;
  logic        m_fence;

  initial begin
    vecs[0]  = '{2'd1, 12'h340, 32'hDEADBEEF, 1'b0, 2'd3, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[1]  = '{2'd2, 12'h304, 32'h00000080, 1'b0, 2'd3, 32'h00000008, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000088, 32'h00000008, 1'b0};
    vecs[2]  = '{2'd3, 12'hC00, 32'h00000000, 1'b1, 2'd3, 32'h00000055, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000055, 32'h00000055, 1'b0};
    vecs[3]  = '{2'd1, 12'h300, 32'h00000001, 1'b0, 2'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000001, 32'h00000000, 1'b1};
    vecs[4]  = '{2'd1, 12'hC01, 32'h00000007, 1'b0, 2'd3, 32'h00000009, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000007, 32'h00000009, STRICT};
    vecs[5]  = '{2'd3, 12'h340, 32'h0000000F, 1'b0, 2'd3, 32'h000000FF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h000000F0, 32'h000000FF, 1'b0};
    vecs[6]  = '{2'd1, 12'h7C0, 32'h00000011, 1'b0, 2'd3, 32'h00000022, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000011, 32'h00000022, 1'b1};
    vecs[7]  = '{2'd2, 12'h344, 32'h00000000, 1'b1, 2'd3, 32'h000000A5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000A5, 32'h000000A5, 1'b0};
    vecs[8]  = '{2'd2, 12'h100, 32'h00000003, 1'b0, 2'd1, 32'h00000004, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000007, 32'h00000004, 1'b0};
    vecs[9]  = '{2'd2, 12'h300, 32'h00000003, 1'b0, 2'd1, 32'h00000004, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000007, 32'h00000004, 1'b1};
    vecs[10] = '{2'd0, 12'h340, 32'h00000003, 1'b0, 2'd3, 32'h00000004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0};

    idle_dx();
    stall_wb = 1'b0; kill_wb = 1'b0; prv = 2'd3;
    csr_rdata = 32'hCAFEF00D; csr_defined = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #4;
    check("reset csr_en", csr_en, 0);
    check("reset csr_wen", csr_wen, 0);
    check("reset csr_addr", csr_addr, 0);
    check("reset csr_wdata", csr_wdata, 0);
    check("reset rd_wdata", rd_wdata_wb, 0);
    check("reset illegal", illegal_csr_wb, 0);
    check("reset fence", fence_dx, 0);
    #1;

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].cmd, vecs[i].addr, vecs[i].op, vecs[i].sz);
      next_cycle();
      idle_dx();
      prv = vecs[i].prv; csr_rdata = vecs[i].rdata; csr_defined = vecs[i].def;
      #4;
      check($sformatf("vec%0d csr_addr", i), csr_addr, vecs[i].addr);
      check($sformatf("vec%0d csr_en", i), csr_en, vecs[i].exp_en);
      check($sformatf("vec%0d csr_wen", i), csr_wen, vecs[i].exp_wen);
      if (vecs[i].chk_wd) check($sformatf("vec%0d csr_wdata", i), csr_wdata, vecs[i].exp_wd);
      check($sformatf("vec%0d rd_wdata", i), rd_wdata_wb, vecs[i].exp_rd);
      check($sformatf("vec%0d illegal", i), illegal_csr_wb, vecs[i].exp_ill);
      next_cycle();
      prv = 2'd3; csr_defined = 1'b1;
      next_cycle();
    end

    // ---------------- fence after MIE set ----------------
    issue(2'd2, 12'h304, 32'h80, 1'b0);
    next_cycle();
    idle_dx(); csr_rdata = 32'h08; prv = 2'd3;
    #4;
    check("fence wen", csr_wen, 1);
    check("fence not yet", fence_dx, 0);
    next_cycle(); #4;
    check("fence asserted", fence_dx, 1);
    next_cycle(); #4;
    check("fence one cycle", fence_dx, 0);
    next_cycle();

    // ---------------- stall then release: single write ----------------
    issue(2'd1, 12'h340, 32'h11112222, 1'b0);
    next_cycle();
    idle_dx(); stall_wb = 1'b1; csr_rdata = 32'h5;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("stall en", csr_en, 1);
      check("stall no wen", csr_wen, 0);
      next_cycle();
    end
    stall_wb = 1'b0;
    #4;
    check("release wen", csr_wen, 1);
    check("release wdata", csr_wdata, 32'h11112222);
    next_cycle(); #4;
    check("release once", csr_wen, 0);
    next_cycle();

    // ---------------- stall 3 cycles then kill on release ----------------
    issue(2'd1, 12'h340, 32'hDEADBEEF, 1'b0);
    next_cycle();
    idle_dx(); stall_wb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("stallkill no wen", csr_wen, 0);
      next_cycle();
    end
    stall_wb = 1'b0; kill_wb = 1'b1;
    #4;
    check("kill wen", csr_wen, 0);
    check("kill en", csr_en, 0);
    check("kill illegal", illegal_csr_wb, 0);
    next_cycle();
    kill_wb = 1'b0;
    #4;
    check("after kill en", csr_en, 0);
    check("after kill wen", csr_wen, 0);
    next_cycle();

    // ---------------- illegal held by stall: one pulse on release ----------------
    issue(2'd1, 12'h300, 32'h1, 1'b0);
    next_cycle();
    idle_dx(); stall_wb = 1'b1; prv = 2'd0;
    #4;
    check("ill stalled", illegal_csr_wb, 0);
    next_cycle();
    stall_wb = 1'b0;
    #4;
    check("ill release", illegal_csr_wb, 1);
    check("ill no wen", csr_wen, 0);
    next_cycle(); #4;
    check("ill single pulse", illegal_csr_wb, 0);
    prv = 2'd3;
    next_cycle();

    // ---------------- reset mid-stall ----------------
    issue(2'd1, 12'h304, 32'h8, 1'b0);
    next_cycle();
    idle_dx(); stall_wb = 1'b1; reset = 1'b1;
    next_cycle();
    reset = 1'b0; stall_wb = 1'b0;
    #4;
    check("rst-stall en", csr_en, 0);
    check("rst-stall wen", csr_wen, 0);
    next_cycle(); #4;
    check("rst-stall fence", fence_dx, 0);
    next_cycle();

    // ---------------- random traffic vs behavioural model ----------------
    m_valid = 1'b0; m_cmd = 2'd0; m_addr = 12'h0; m_op = 32'h0; m_sz = 1'b0; m_fence = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] addrs [8];
      logic [1:0]  prvs  [3];
      logic        e_en, e_wr, e_ill_raw, e_wen, e_ill, e_rowr;
      logic [31:0] e_wd;
      addrs = '{12'h300, 12'h304, 12'h344, 12'h340, 12'hC00, 12'hC01, 12'h100, 12'h7C0};
      prvs  = '{2'd0, 2'd1, 2'd3};
      valid_dx       = ($urandom_range(0, 3) != 0);
      csr_cmd_dx     = 2'($urandom_range(0, 3));
      csr_addr_dx    = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 7)];
      csr_operand_dx = $urandom;
      src_zero_dx    = ($urandom_range(0, 3) == 0);
      stall_wb       = ($urandom_range(0, 3) == 0);
      kill_wb        = ($urandom_range(0, 9) == 0);
      prv            = prvs[$urandom_range(0, 2)];
      csr_rdata      = $urandom;
      csr_defined    = ($urandom_range(0, 9) != 0);
      #4;
      // Expected behaviour from the instruction the model holds in WB
      e_en = m_valid && (m_cmd != 2'd0) && !kill_wb;
      case (m_cmd)
        2'd1:    begin e_wr = 1'b1;  e_wd = m_op; end
        2'd2:    begin e_wr = !m_sz; e_wd = csr_rdata | m_op; end
        2'd3:    begin e_wr = !m_sz; e_wd = csr_rdata & ~m_op; end
        default: begin e_wr = 1'b0;  e_wd = 32'h0; end
      endcase
      e_rowr    = e_wr && (m_addr >= 12'hC00);
      e_ill_raw = e_en && (!csr_defined || (int'(m_addr[9:8]) > int'(prv)) || (STRICT && e_rowr));
      e_ill     = e_ill_raw && !stall_wb;
      e_wen     = e_en && e_wr && !e_ill_raw && !e_rowr && !stall_wb;
      check("rnd csr_en", csr_en, e_en);
      check("rnd csr_addr", csr_addr, m_addr);
      check("rnd csr_wen", csr_wen, e_wen);
      check("rnd illegal", illegal_csr_wb, e_ill);
      check("rnd rd_wdata", rd_wdata_wb, e_en ? csr_rdata : 32'h0);
      check("rnd fence", fence_dx, m_fence);
      if (e_en) check("rnd csr_wdata", csr_wdata, e_wd);
      @(posedge clk);
      m_fence = !m_fence && e_wen && (m_addr == 12'h300 || m_addr == 12'h304 || m_addr == 12'h344);
      if (!stall_wb) begin
        m_valid = valid_dx; m_cmd = csr_cmd_dx; m_addr = csr_addr_dx;
        m_op = csr_operand_dx; m_sz = src_zero_dx;
      end
      if (kill_wb) m_valid = 1'b0;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vscale_csr_access_stage.md
Name: vscale_csr_access_stage

Overview:
Pipeline stage directly upstream of the CSR register file. It captures CSR instructions leaving decode/execute (DX) into a write-back (WB) register and drives the CSR file's addr/en/wen/wdata. It also performs the read-modify-write for CSRRW/CSRRS/CSRRC, detects illegal CSR accesses, supplies the old CSR value to rd, and fences the next instruction after interrupt-enable-affecting writes.

Parameters:
XPR_LEN, 32, data width of CSR operands and values
CSR_ADDR_W, 12, CSR address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_dx  in  1  DX holds a valid instruction
csr_cmd_dx  in  2  0 NONE, 1 RW (write), 2 RS (set), 3 RC (clear)
csr_addr_dx  in  CSR_ADDR_W  CSR address from instruction
csr_operand_dx  in  XPR_LEN  rs1 value or zero-extended zimm
src_zero_dx  in  1  rs1 is x0 / zimm==0
stall_wb  in  1  hold WB register
kill_wb  in  1  squash the WB instruction (trap/redirect)
prv  in  2  current privilege level (00 U, 11 M)
csr_rdata  in  XPR_LEN  combinational read data from the CSR file
csr_defined  in  1  CSR file decodes addr as implemented
csr_addr  out  CSR_ADDR_W  to CSR file
csr_en  out  1  CSR access active in WB
csr_wen  out  1  CSR write strobe
csr_wdata  out  XPR_LEN  value to write
rd_wdata_wb  out  XPR_LEN  old CSR value, for rd / bypass
illegal_csr_wb  out  1  illegal-instruction exception request
fence_dx  out  1  hold DX for one cycle

Behaviour:
- WB register (valid_wb, cmd_wb, addr_wb, operand_wb, src_zero_wb) loads from DX each cycle unless stall_wb. While stall_wb is high it holds; kill_wb clears valid_wb on the same edge, and kill_wb has priority over stall_wb.
- Reset: valid_wb=0, cmd_wb=NONE, addr_wb=0, operand_wb=0, fence state=0. All outputs 0 in the cycle after reset.
- Latency: a DX command is presented to the CSR file exactly 1 cycle later (WB).
- csr_addr=addr_wb. csr_en = valid_wb & cmd_wb!=NONE & !kill_wb.
- wdata: RW -> operand_wb; RS -> csr_rdata | operand_wb; RC -> csr_rdata & ~operand_wb. Computed at full XPR_LEN with no truncation.
- write_req = (cmd_wb==RW) | ((cmd_wb==RS|RC) & !src_zero_wb).
- illegal = csr_en & (!csr_defined | addr_wb[9:8] > prv | RO_VIOLATION).
- RO_VIOLATION = write_req & addr_wb[11:10]==2'b11, subject to the optional feature.
- csr_wen = csr_en & write_req & !illegal & !stall_wb. While stalled there is no write; the write issues on the release cycle, once only.
- illegal_csr_wb = illegal & !stall_wb. It is a single-cycle pulse per instruction.
- rd_wdata_wb = csr_rdata when csr_en, else 0.
- Fence FSM, states IDLE and FENCE:
  - IDLE -> FENCE when csr_wen and addr_wb is MSTATUS (0x300), MIE (0x304) or MIP (0x344).
  - FENCE asserts fence_dx for exactly one cycle, then -> IDLE.
  - reset or kill_wb in FENCE -> IDLE.
  - Back-to-back qualifying writes cannot occur because DX is held.
- Simultaneous kill_wb with a legal write: no write and no illegal pulse.
- Reset mid-stall: the WB instruction is discarded and no write occurs.

Optional Feature:
VSCALE_CSR_STRICT_RO_EN
- Defined: writes (write_req) to addr[11:10]==2'b11 raise illegal_csr_wb and suppress csr_wen.
- Undefined: RO_VIOLATION is 0. Such writes are silently dropped (csr_wen=0), rd_wdata_wb is still returned, and no exception is raised.

Test Plan:
- CSRRW 0x340 (MSCRATCH), operand 0xDEADBEEF, prv=11, rdata 0x12345678 -> next cycle csr_wen=1, csr_wdata=0xDEADBEEF, rd_wdata_wb=0x12345678, illegal=0.
- CSRRS 0x304, rdata 0x08, operand 0x80 -> csr_wdata=0x88, csr_wen=1; the next cycle fence_dx=1 for exactly 1 cycle.
- CSRRC with src_zero_dx=1 at 0xC00 (CYCLE), rdata 0x55 -> csr_wen=0, rd_wdata_wb=0x55, illegal=0 under either build.
- CSRRW 0x300 with prv=00 -> illegal_csr_wb=1 for 1 cycle, csr_wen=0.
- CSRRW 0xC01 with prv=11 -> with VSCALE_CSR_STRICT_RO_EN defined, illegal=1 and csr_wen=0; undefined, illegal=0 and csr_wen=0.
- CSRRW 0x340 held 3 cycles by stall_wb, then kill_wb on the release cycle -> csr_wen never asserts and valid_wb=0 afterwards.
